gray_bin_threshold: RTL and testbench

//  Parametrised gray-to-binary thresholder placed after the grayscale stage in the capture pipeline.
//  - Three modes: fixed, hysteresis, and auto-mean (threshold = mean of a sample window from the previous frame).
//  - Threshold and mode updates are shadowed and applied only at frame start, so a frame never tears.
//  - Output is full-scale white or zero, registered, with 1-cycle latency.

---
 rtl/gray_bin_threshold.sv | 260 ++++++++++++++++++++++++++
 tb/tb_gray_bin_threshold.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_bin_threshold.sv
// gray_bin_threshold: gray-to-binary thresholder for the capture pipeline.
//
// Modes (active mode register):
//   0 / 3 : fixed threshold, white iff pixel > TH_HI
//   1     : hysteresis between TH_LO and TH_HI
//   2     : auto-mean; threshold is the mean of the first 2**LOG2_SAMPLES
//           in-frame pixels of the last complete frame
//
// Threshold and mode changes go to a shadow set and only become active at
// frame start, so one frame is always binarized with one threshold set.
//
// Optional feature macro: GRAY2BIN_STATS_EN adds a per-frame white-pixel
// counter (oWHITE_CNT) with a one-cycle frame-end strobe (oSTAT_VLD).
//
// Stream semantics: there is no back-pressure. A pixel is transferred on
// every rising iCLK edge where iDVAL=1; oDVAL/oDATA present the result of
// that pixel exactly one cycle later. oDATA holds when no pixel arrives.
module gray_bin_threshold #(
  parameter int DATA_W       = 12,
  parameter int TH_HI_DEF    = 3747,
  parameter int TH_LO_DEF    = 3500,
  parameter int LOG2_SAMPLES = 10,
  parameter int CNT_W        = 22
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic              iFVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic [1:0]        iMODE,
  input  logic [DATA_W-1:0] iTH_HI,
  input  logic [DATA_W-1:0] iTH_LO,
  input  logic              iTH_LD,
  output logic              oDVAL,
  output logic [DATA_W-1:0] oDATA,
  output logic [DATA_W-1:0] oTH
`ifdef GRAY2BIN_STATS_EN
  ,
  output logic [CNT_W-1:0]  oWHITE_CNT,
  output logic              oSTAT_VLD
`endif
);

  // Accumulator must hold the sum of 2**LOG2_SAMPLES full-scale pixels.
  localparam int ACC_W = DATA_W + LOG2_SAMPLES;
  // Sample counter must be able to reach 2**LOG2_SAMPLES itself.
  localparam int SCN_W = LOG2_SAMPLES + 1;
  localparam logic [SCN_W-1:0] N_SAMP = SCN_W'(2 ** LOG2_SAMPLES);

  localparam logic [1:0] MODE_FIXED = 2'd0;
  localparam logic [1:0] MODE_HYST  = 2'd1;
  localparam logic [1:0] MODE_AUTO  = 2'd2;

  // Elaboration-time sanity check of the configuration.
  if (DATA_W < 1 || LOG2_SAMPLES < 0 || CNT_W < 1) begin : g_bad_param
    $error("gray_bin_threshold: illegal parameter combination");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              fval_q;
  logic              pend_q,     pend_d;
  logic [DATA_W-1:0] sh_hi_q,    sh_hi_d;
  logic [DATA_W-1:0] sh_lo_q,    sh_lo_d;
  logic [1:0]        sh_mode_q,  sh_mode_d;
  logic [DATA_W-1:0] act_hi_q,   act_hi_d;
  logic [DATA_W-1:0] act_lo_q,   act_lo_d;
  logic [1:0]        act_mode_q, act_mode_d;
  logic              h_q,        h_d;
  logic [ACC_W-1:0]  acc_q,      acc_d;
  logic [SCN_W-1:0]  scnt_q,     scnt_d;
  logic [DATA_W-1:0] auto_th_q,  auto_th_d;
  logic              auto_vld_q, auto_vld_d;
  logic              dval_q;
  logic [DATA_W-1:0] data_q,     data_d;
  logic [DATA_W-1:0] th_q,       th_d;

  // Frame edges, derived from the registered copy of iFVAL.
  logic frame_start;
  logic frame_end;
  assign frame_start = iFVAL & ~fval_q;
  assign frame_end   = ~iFVAL & fval_q;

  // Settings in force for the current cycle (already switched on the
  // frame-start cycle so the first pixel of a frame uses the new set).
  logic [DATA_W-1:0] eff_hi;
  logic [DATA_W-1:0] eff_lo_raw;
  logic [DATA_W-1:0] eff_lo;
  logic [1:0]        eff_mode;
  logic [DATA_W-1:0] th_auto;
  logic [DATA_W-1:0] th_eff;
  logic              h_base;
  logic              white;
  logic              sample_en;

  // Shadow/active threshold selection and frame-start handover.
  always_comb begin
    eff_hi     = act_hi_q;
    eff_lo_raw = act_lo_q;
    eff_mode   = act_mode_q;
    sh_hi_d    = sh_hi_q;
    sh_lo_d    = sh_lo_q;
    sh_mode_d  = sh_mode_q;
    pend_d     = pend_q;

    if (frame_start && iTH_LD) begin
      // Load coinciding with frame start takes effect for this frame.
      eff_hi     = iTH_HI;
      eff_lo_raw = iTH_LO;
      eff_mode   = iMODE;
    end else if (frame_start && pend_q) begin
      eff_hi     = sh_hi_q;
      eff_lo_raw = sh_lo_q;
      eff_mode   = sh_mode_q;
    end

    if (iTH_LD) begin
      sh_hi_d   = iTH_HI;
      sh_lo_d   = iTH_LO;
      sh_mode_d = iMODE;
      pend_d    = ~frame_start;
    end else if (frame_start) begin
      pend_d    = 1'b0;
    end

    act_hi_d   = eff_hi;
    act_lo_d   = eff_lo_raw;
    act_mode_d = eff_mode;

    // An inverted hysteresis window collapses to a single threshold.
    eff_lo  = (eff_lo_raw > eff_hi) ? eff_hi : eff_lo_raw;
    th_auto = auto_vld_q ? auto_th_q : eff_hi;
    th_eff  = (eff_mode == MODE_AUTO) ? th_auto : eff_hi;
  end

  // Binarization, hysteresis bit and output/threshold next-state.
  always_comb begin
    h_base = frame_start ? 1'b0 : h_q;
    h_d    = h_base;
    white  = 1'b0;

    case (eff_mode)
      MODE_HYST: begin
        if (iDATA > eff_hi) begin
          white = 1'b1;
          if (iDVAL) h_d = 1'b1;
        end else if (iDATA < eff_lo) begin
          white = 1'b0;
          if (iDVAL) h_d = 1'b0;
        end else begin
          white = h_base;
        end
      end
      MODE_AUTO:  white = (iDATA > th_auto);
      MODE_FIXED: white = (iDATA > eff_hi);
      default:    white = (iDATA > eff_hi);
    endcase

    data_d = data_q;
    if (iDVAL) data_d = white ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

    th_d = frame_start ? th_eff : th_q;
  end

  // Auto-mean sampling: runs in every mode on in-frame valid pixels.
  always_comb begin
    sample_en = iDVAL & iFVAL;
    acc_d     = frame_start ? '0 : acc_q;
    scnt_d    = frame_start ? '0 : scnt_q;
    if (sample_en && (scnt_d < N_SAMP)) begin
      acc_d  = acc_d + ACC_W'(iDATA);
      scnt_d = scnt_d + SCN_W'(1);
    end

    auto_th_d  = auto_th_q;
    auto_vld_d = auto_vld_q;
    // Short frames leave the previous auto threshold in place.
    if (frame_end && (scnt_q == N_SAMP)) begin
      auto_th_d  = acc_q[ACC_W-1:LOG2_SAMPLES];
      auto_vld_d = 1'b1;
    end
  end

  // State registers; reset restores defaults at any point in a frame.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fval_q     <= 1'b0;
      pend_q     <= 1'b0;
      sh_hi_q    <= DATA_W'(TH_HI_DEF);
      sh_lo_q    <= DATA_W'(TH_LO_DEF);
      sh_mode_q  <= MODE_FIXED;
      act_hi_q   <= DATA_W'(TH_HI_DEF);
      act_lo_q   <= DATA_W'(TH_LO_DEF);
      act_mode_q <= MODE_FIXED;
      h_q        <= 1'b0;
      acc_q      <= '0;
      scnt_q     <= '0;
      auto_th_q  <= '0;
      auto_vld_q <= 1'b0;
      dval_q     <= 1'b0;
      data_q     <= '0;
      th_q       <= DATA_W'(TH_HI_DEF);
    end else begin
      fval_q     <= iFVAL;
      pend_q     <= pend_d;
      sh_hi_q    <= sh_hi_d;
      sh_lo_q    <= sh_lo_d;
      sh_mode_q  <= sh_mode_d;
      act_hi_q   <= act_hi_d;
      act_lo_q   <= act_lo_d;
      act_mode_q <= act_mode_d;
      h_q        <= h_d;
      acc_q      <= acc_d;
      scnt_q     <= scnt_d;
      auto_th_q  <= auto_th_d;
      auto_vld_q <= auto_vld_d;
      dval_q     <= iDVAL;
      data_q     <= data_d;
      th_q       <= th_d;
    end
  end

  assign oDVAL = dval_q;
  assign oDATA = data_q;
  assign oTH   = th_q;

`ifdef GRAY2BIN_STATS_EN
  logic [CNT_W-1:0] wcnt_q,  wcnt_d;
  logic [CNT_W-1:0] wstat_q, wstat_d;
  logic             svld_q,  svld_d;

  // White-pixel counter: clears at frame start, saturates at all-ones.
  always_comb begin
    wcnt_d = frame_start ? '0 : wcnt_q;
    if (iDVAL && iFVAL && white && (wcnt_d != {CNT_W{1'b1}})) begin
      wcnt_d = wcnt_d + CNT_W'(1);
    end
    wstat_d = frame_end ? wcnt_q : wstat_q;
    svld_d  = frame_end;
  end

  // Statistics registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wcnt_q  <= '0;
      wstat_q <= '0;
      svld_q  <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wstat_q <= wstat_d;
      svld_q  <= svld_d;
    end
  end

  assign oWHITE_CNT = wstat_q;
  assign oSTAT_VLD  = svld_q;
`endif

endmodule

// File: tb/tb_gray_bin_threshold.sv
// Directed testbench for gray_bin_threshold (DATA_W=12, LOG2_SAMPLES=2).
module tb_gray_bin_threshold;

  localparam int DW = 12;
  localparam logic [DW-1:0] WH = 12'hFFF;

  logic          iCLK;
  logic          iRST;
  logic          iDVAL;
  logic          iFVAL;
  logic [DW-1:0] iDATA;
  logic [1:0]    iMODE;
  logic [DW-1:0] iTH_HI;
  logic [DW-1:0] iTH_LO;
  logic          iTH_LD;
  logic          oDVAL;
  logic [DW-1:0] oDATA;
  logic [DW-1:0] oTH;

  int n_cmp = 0;
  int n_err = 0;

`ifdef GRAY2BIN_STATS_EN
  logic [21:0] oWHITE_CNT;
  logic        oSTAT_VLD;
  logic [2:0]  sat_cnt;
  logic        sat_vld;
  logic        sat_dval;
  logic [DW-1:0] sat_data;
  logic [DW-1:0] sat_th;
`endif

  gray_bin_threshold #(
    .DATA_W(DW), .TH_HI_DEF(3747), .TH_LO_DEF(3500), .LOG2_SAMPLES(2), .CNT_W(22)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iFVAL(iFVAL), .iDATA(iDATA),
    .iMODE(iMODE), .iTH_HI(iTH_HI), .iTH_LO(iTH_LO), .iTH_LD(iTH_LD),
    .oDVAL(oDVAL), .oDATA(oDATA), .oTH(oTH)
`ifdef GRAY2BIN_STATS_EN
    , .oWHITE_CNT(oWHITE_CNT), .oSTAT_VLD(oSTAT_VLD)
`endif
  );

`ifdef GRAY2BIN_STATS_EN
  gray_bin_threshold #(
    .DATA_W(DW), .TH_HI_DEF(3747), .TH_LO_DEF(3500), .LOG2_SAMPLES(2), .CNT_W(3)
  ) dut_sat (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iFVAL(iFVAL), .iDATA(iDATA),
    .iMODE(iMODE), .iTH_HI(iTH_HI), .iTH_LO(iTH_LO), .iTH_LD(iTH_LD),
    .oDVAL(sat_dval), .oDATA(sat_data), .oTH(sat_th),
    .oWHITE_CNT(sat_cnt), .oSTAT_VLD(sat_vld)
  );
`endif

  // Clock and watchdog
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected summary before 200000");
    $fatal(1, "watchdog expired");
  end

  // Comparison point
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: one clock cycle of stream input, outputs sampled 1 time unit after the edge
  task automatic step(input logic dv, input logic fv, input logic [DW-1:0] d);
    @(negedge iCLK);
    iDVAL  = dv;
    iFVAL  = fv;
    iDATA  = d;
    iTH_LD = 1'b0;
    @(posedge iCLK);
    #1;
  endtask

  // Driver: same as step, with a threshold/mode load strobe in that cycle
  task automatic step_ld(input logic dv, input logic fv, input logic [DW-1:0] d,
                         input logic [DW-1:0] hi, input logic [DW-1:0] lo, input logic [1:0] md);
    @(negedge iCLK);
    iDVAL  = dv;
    iFVAL  = fv;
    iDATA  = d;
    iTH_HI = hi;
    iTH_LO = lo;
    iMODE  = md;
    iTH_LD = 1'b1;
    @(posedge iCLK);
    #1;
  endtask

  // In-frame pixel with expected binarized result
  task automatic px(input string tag, input logic [DW-1:0] d, input logic [DW-1:0] exp);
    step(1'b1, 1'b1, d);
    check(tag, oDATA, exp);
  endtask

  // Asynchronous reset pulse, checked while held
  task automatic do_reset();
    @(negedge iCLK);
    iRST   = 1'b0;
    iDVAL  = 1'b0;
    iFVAL  = 1'b0;
    iTH_LD = 1'b0;
    #1;
    check("rst_odata", oDATA, 0);
    check("rst_odval", oDVAL, 0);
    check("rst_oth",   oTH, 3747);
    @(negedge iCLK);
    iRST = 1'b1;
  endtask

  initial begin
    iRST = 1'b0; iDVAL = 1'b0; iFVAL = 1'b0; iDATA = '0;
    iMODE = 2'd0; iTH_HI = '0; iTH_LO = '0; iTH_LD = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    check("init_odval", oDVAL, 0);
    check("init_odata", oDATA, 0);
    check("init_oth",   oTH, 3747);
`ifdef GRAY2BIN_STATS_EN
    check("init_wcnt", oWHITE_CNT, 0);
    check("init_svld", oSTAT_VLD, 0);
`endif
    @(negedge iCLK);
    iRST = 1'b1;
    step(0, 0, 0);

    // 1: fixed mode at reset thresholds (frame 1 samples 3747,3748,0,4095)
    px("t1_3747", 3747, 0);
    check("t1_odval", oDVAL, 1);
    check("t1_oth", oTH, 3747);
    px("t1_3748", 3748, WH);
    px("t1_0", 0, 0);
    px("t1_4095", 4095, WH);
    step(0, 1, 0);
    check("t1_idle_dval", oDVAL, 0);
    check("t1_hold", oDATA, WH);

    // 2: mid-frame load only takes effect at the next frame
    step_ld(1, 1, 200, 100, 0, 0);
    check("t2_oldth_px", oDATA, 0);
    check("t2_oldth_oth", oTH, 3747);
    step(0, 0, 0);
    px("t2_new_101", 101, WH);
    check("t2_new_oth", oTH, 100);
    px("t2_new_100", 100, 0);
    step(0, 0, 0);

    // 3: hysteresis, load coinciding with frame start (samples 500,1500,2500,1500 -> 1500)
    step_ld(1, 1, 500, 2000, 1000, 1);
    check("t3_500", oDATA, 0);
    check("t3_oth", oTH, 2000);
    px("t3_1500a", 1500, 0);
    px("t3_2500", 2500, WH);
    px("t3_1500b", 1500, WH);
    px("t3_900", 900, 0);
    px("t3_1500c", 1500, 0);
    px("t3_2500b", 2500, WH);
    step(0, 0, 0);
    px("t3_newframe", 1500, 0);
    step(0, 0, 0);

    // 4: auto-mean; frame A starts with the mean from frame 3
    step_ld(0, 0, 0, 3747, 3500, 2);
    px("t4a_100", 100, 0);
    check("t4a_oth", oTH, 1500);
    px("t4a_200", 200, 0);
    px("t4a_300", 300, 0);
    px("t4a_400", 400, 0);
    px("t4a_4000", 4000, WH);
    step(0, 0, 0);
    px("t4b_251", 251, WH);
    check("t4b_oth", oTH, 250);
    px("t4b_250", 250, 0);
    px("t4b_0", 0, 0);
    step(0, 0, 0);
    px("t4c_251", 251, WH);
    check("t4c_oth_short", oTH, 250);
    step(0, 0, 0);

    // Hysteresis with inverted window: LO clamps to HI=1000
    step_ld(0, 0, 0, 1000, 3000, 1);
    px("clamp_1001", 1001, WH);
    check("clamp_oth", oTH, 1000);
    px("clamp_1000a", 1000, WH);
    px("clamp_999", 999, 0);
    px("clamp_1000b", 1000, 0);
    step(0, 0, 0);

    // Last shadow write wins; pixels outside the frame still binarize
    step_ld(0, 0, 0, 500, 0, 0);
    step_ld(0, 0, 0, 600, 0, 0);
    px("lww_550", 550, 0);
    check("lww_oth", oTH, 600);
    step(0, 0, 0);
    step(1, 0, 700);
    check("outside_700", oDATA, WH);
    check("outside_dval", oDVAL, 1);

    // 5: reset mid-frame in hysteresis with h=1 and a pending load
    step_ld(1, 1, 2500, 2000, 1000, 1);
    check("t5_h1", oDATA, WH);
    check("t5_oth", oTH, 2000);
    step_ld(1, 1, 2500, 5, 5, 2);
    check("t5_pend_px", oDATA, WH);
    do_reset();
    step(0, 0, 0);
    px("t5_post_3748", 3748, WH);
    check("t5_post_oth", oTH, 3747);
    px("t5_post_3600", 3600, 0);
    step(0, 0, 0);
    step_ld(1, 1, 3748, 3747, 3500, 2);
    check("t5_auto_inv_px", oDATA, WH);
    check("t5_auto_inv_oth", oTH, 3747);
    px("t5_auto_3747", 3747, 0);
    step(0, 0, 0);

`ifdef GRAY2BIN_STATS_EN
    // 6: white-pixel statistics and saturation
    do_reset();
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) px("t6_white", 4000, WH);
    for (int i = 0; i < 3; i++) px("t6_black", 0, 0);
    check("t6_svld_pre", oSTAT_VLD, 0);
    step(0, 0, 0);
    check("t6_svld", oSTAT_VLD, 1);
    check("t6_wcnt", oWHITE_CNT, 5);
    step(0, 0, 0);
    check("t6_svld_off", oSTAT_VLD, 0);
    for (int i = 0; i < 9; i++) px("t6_sat_px", 4000, WH);
    step(0, 0, 0);
    check("t6_wcnt9", oWHITE_CNT, 9);
    check("t6_sat", sat_cnt, 7);
    check("t6_sat_vld", sat_vld, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
